// File: rtl/weight_buffer_pingpong.sv
// Double-buffered filter-weight store: a valid/ready loader fills the shadow bank
// while the compute side reads whole filters from the active bank.
module weight_buffer_pingpong #(
  parameter int Bit_width            = 8,
  parameter int Nr_depth             = 8,
  parameter int Depth_counter_bits   = 3,
  parameter int Nr_feature           = 6,
  parameter int Feature_counter_bits = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_load_start,
  input  logic                            i_load_valid,
  output logic                            o_load_ready,
  input  logic [Bit_width-1:0]            i_load_data,
  output logic                            o_shadow_full,
  input  logic                            i_swap_req,
  output logic                            o_swap_ack,
  output logic                            o_active_bank,
  input  logic                            i_read_en,
  input  logic [Depth_counter_bits-1:0]   i_read_addr,
  output logic                            o_read_valid,
  output logic [Bit_width*Nr_feature-1:0] o_read_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FULL
  } state_t;

  localparam logic [Feature_counter_bits-1:0] LP_LAST_FEAT = Feature_counter_bits'(Nr_feature - 1);
  localparam logic [Depth_counter_bits-1:0]   LP_LAST_FILT = Depth_counter_bits'(Nr_depth - 1);

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [Feature_counter_bits-1:0]   r_feat;
  logic [Depth_counter_bits-1:0]     r_filt;
  logic                              r_active_bank;
  logic                              r_read_valid;
  logic [Bit_width*Nr_feature-1:0]   r_read_data;
  logic [Bit_width*Nr_feature-1:0]   w_read_row;
  logic                              w_load_fire;
  logic                              w_last_beat;
  logic                              w_swap;
  logic                              w_restart;
  logic                              w_addr_ok;

  logic [Bit_width-1:0] r_mem [0:1][0:Nr_depth-1][0:Nr_feature-1];

  // A beat coinciding with Load_start belongs to the abandoned load and is dropped.
  assign w_load_fire = (r_state == ST_LOAD) && i_load_valid && !i_load_start;
  assign w_last_beat = w_load_fire && (r_feat == LP_LAST_FEAT) && (r_filt == LP_LAST_FILT);
  assign w_swap      = (r_state == ST_FULL) && i_swap_req;
  assign w_restart   = i_load_start && !w_swap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_load_ready  = 1'b0;
    o_shadow_full = 1'b0;
    o_swap_ack    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_load_start) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        o_load_ready = 1'b1;
        if (w_last_beat) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        o_shadow_full = 1'b1;
        if (w_swap) begin
          o_swap_ack  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (i_load_start) begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_feat <= '0;
      r_filt <= '0;
    end else if (w_restart) begin
      r_feat <= '0;
      r_filt <= '0;
    end else if (w_load_fire) begin
      if (r_feat == LP_LAST_FEAT) begin
        r_feat <= '0;
        r_filt <= r_filt + 1'b1;
      end else begin
        r_feat <= r_feat + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active_bank <= 1'b0;
    end else if (w_swap) begin
      r_active_bank <= ~r_active_bank;
    end
  end

  // Storage is deliberately not reset; only the shadow bank is ever written.
  always_ff @(posedge i_clk) begin
    if (w_load_fire) begin
      r_mem[~r_active_bank][r_filt][r_feat] <= i_load_data;
    end
  end

  assign w_addr_ok = 32'(i_read_addr) < Nr_depth;

  always_comb begin
    w_read_row = '0;
    if (w_addr_ok) begin
      for (int f = 0; f < Nr_feature; f++) begin
        w_read_row[f*Bit_width +: Bit_width] = r_mem[r_active_bank][i_read_addr][f];
      end
    end
  end

  // Reads use the bank active at the sampling edge, so a swap-cycle read sees the old bank.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_read_valid <= 1'b0;
      r_read_data  <= '0;
    end else begin
      r_read_valid <= i_read_en;
      if (i_read_en) begin
        r_read_data <= w_read_row;
      end
    end
  end

  assign o_active_bank = r_active_bank;
  assign o_read_valid  = r_read_valid;
  assign o_read_data   = r_read_data;

endmodule

// File: tb/tb_weight_buffer_pingpong.sv
// Self-checking bench for weight_buffer_pingpong: directed scenarios plus random
// traffic, all compared against a word-count based behavioural model.
module tb_weight_buffer_pingpong;

  localparam int BW = 8;
  localparam int ND = 8;
  localparam int NF = 6;
  localparam int NW = ND * NF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start, load_valid, swap_req, read_en;
  logic [BW-1:0] load_data;
  logic [2:0]    read_addr;
  logic          load_ready, shadow_full, swap_ack, active_bank, read_valid;
  logic [BW*NF-1:0] read_data;

  logic          sReadEn;
  logic [2:0]    sReadAddr;
  logic          sLoadReady, sShadowFull, sSwapAck, sActiveBank, sReadValid;
  logic [BW*NF-1:0] sReadData;

  // Behavioural model: mode 0=idle 1=loading 2=full, loader position as a flat word count.
  logic [BW-1:0]    mMem [2][ND][NF];
  int               mMode;
  int               mCnt;
  logic             mActive;
  logic             mValid;
  logic [BW*NF-1:0] mData;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  weight_buffer_pingpong #(
    .Bit_width(BW), .Nr_depth(ND), .Depth_counter_bits(3),
    .Nr_feature(NF), .Feature_counter_bits(3)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_load_start(load_start), .i_load_valid(load_valid), .o_load_ready(load_ready),
    .i_load_data(load_data), .o_shadow_full(shadow_full),
    .i_swap_req(swap_req), .o_swap_ack(swap_ack), .o_active_bank(active_bank),
    .i_read_en(read_en), .i_read_addr(read_addr),
    .o_read_valid(read_valid), .o_read_data(read_data)
  );

  weight_buffer_pingpong #(
    .Bit_width(BW), .Nr_depth(6), .Depth_counter_bits(3),
    .Nr_feature(NF), .Feature_counter_bits(3)
  ) smallDut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_load_start(1'b0), .i_load_valid(1'b0), .o_load_ready(sLoadReady),
    .i_load_data('0), .o_shadow_full(sShadowFull),
    .i_swap_req(1'b0), .o_swap_ack(sSwapAck), .o_active_bank(sActiveBank),
    .i_read_en(sReadEn), .i_read_addr(sReadAddr),
    .o_read_valid(sReadValid), .o_read_data(sReadData)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW*NF-1:0] rowOf(input logic bank, input int addr);
    logic [BW*NF-1:0] r;
    r = '0;
    if (addr < ND) begin
      for (int f = 0; f < NF; f++) r[f*BW +: BW] = mMem[bank][addr][f];
    end
    return r;
  endfunction

  task automatic modelReset();
    mMode   = 0;
    mCnt    = 0;
    mActive = 1'b0;
    mValid  = 1'b0;
    mData   = '0;
  endtask

  task automatic checkAll();
    checkOutput("load_ready",  64'(load_ready),  64'(mMode == 1));
    checkOutput("shadow_full", 64'(shadow_full), 64'(mMode == 2));
    checkOutput("active_bank", 64'(active_bank), 64'(mActive));
    checkOutput("read_valid",  64'(read_valid),  64'(mValid));
    checkOutput("read_data",   64'(read_data),   64'(mData));
  endtask

  // One clock: drive, check mid-cycle, then advance the model across the edge.
  task automatic applyStimulus(input bit start, input bit valid, input logic [BW-1:0] data,
                               input bit swap, input bit ren, input logic [2:0] addr);
    load_start = start;
    load_valid = valid;
    load_data  = data;
    swap_req   = swap;
    read_en    = ren;
    read_addr  = addr;
    #4;
    checkAll();
    checkOutput("swap_ack", 64'(swap_ack), 64'(mMode == 2 && swap));
    @(posedge clk);
    if (ren) begin
      mValid = 1'b1;
      mData  = rowOf(mActive, int'(addr));
    end else begin
      mValid = 1'b0;
    end
    case (mMode)
      0: if (start) begin mMode = 1; mCnt = 0; end
      1: begin
        if (start) begin
          mCnt = 0;
        end else if (valid) begin
          mMem[!mActive][mCnt / NF][mCnt % NF] = data;
          mCnt++;
          if (mCnt == NW) mMode = 2;
        end
      end
      default: begin
        if (swap) begin
          mActive = !mActive;
          mMode   = 0;
        end else if (start) begin
          mMode = 1;
          mCnt  = 0;
        end
      end
    endcase
    #1;
  endtask

  task automatic loadSeq(input int base, input bit ren, input logic [2:0] addr);
    applyStimulus(1, 0, '0, 0, ren, addr);
    for (int i = 0; i < NW; i++) applyStimulus(0, 1, BW'(base + i), 0, ren, addr);
  endtask

  initial begin
    load_start = 0; load_valid = 0; load_data = '0; swap_req = 0;
    read_en = 0; read_addr = '0; sReadEn = 0; sReadAddr = '0;
    modelReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    rst_n = 1'b1;

    // Full load of the shadow bank, swap, read filter 2
    loadSeq(1, 0, 3'd0);
    applyStimulus(0, 0, '0, 0, 0, 3'd0);
    applyStimulus(0, 0, '0, 1, 0, 3'd0);
    applyStimulus(0, 0, '0, 0, 1, 3'd2);
    checkOutput("lanes_addr2_bank1", 64'(read_data), 64'(48'h12_11_10_0f_0e_0d));

    // Gapped load of the other bank, then Load_valid while full
    begin
      int accepted = 0;
      bool_loop: for (int c = 0; c < 4 * NW && accepted < NW; c++) begin
        if (c == 0) applyStimulus(1, 0, '0, 0, 0, 3'd0);
        else if (c % 2 == 1) begin
          applyStimulus(0, 1, BW'(accepted + 1), 0, 0, 3'd0);
          accepted++;
        end else applyStimulus(0, 0, 8'hEE, 0, 0, 3'd0);
      end
      checkOutput("gapped_accepted", 64'(accepted), 64'(NW));
    end
    repeat (3) applyStimulus(0, 1, 8'hAA, 0, 0, 3'd0);
    applyStimulus(0, 0, '0, 1, 0, 3'd0);
    applyStimulus(0, 0, '0, 0, 1, 3'd2);
    checkOutput("lanes_addr2_bank0", 64'(read_data), 64'(48'h12_11_10_0f_0e_0d));

    // Ping-pong isolation: load 100.. while reading filter 0 every cycle
    loadSeq(100, 1, 3'd0);
    applyStimulus(0, 0, '0, 1, 1, 3'd0);
    checkOutput("swap_cycle_read_old", 64'(read_data), 64'(48'h06_05_04_03_02_01));
    applyStimulus(0, 0, '0, 0, 1, 3'd0);
    checkOutput("after_swap_read_new", 64'(read_data), 64'(48'h69_68_67_66_65_64));

    // Reset mid-load
    applyStimulus(1, 0, '0, 0, 1, 3'd1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, BW'($urandom), 0, 1, 3'd1);
    for (int i = 0; i < 10; i++) mMem[!mActive][i / NF][i % NF] = mMem[!mActive][i / NF][i % NF];
    load_start = 0; load_valid = 1; read_en = 1;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll();
    repeat (2) begin
      @(posedge clk);
      #1;
      checkAll();
    end
    load_valid = 0; read_en = 0;
    rst_n = 1'b1;

    // Ignored early swap, then restart after 30 beats
    applyStimulus(1, 0, '0, 0, 0, 3'd0);
    for (int i = 0; i < 30; i++) applyStimulus(0, 1, BW'($urandom), (i == 20), 0, 3'd0);
    checkOutput("early_swap_bank", 64'(active_bank), 64'(0));
    loadSeq(int'($urandom_range(0, 200)), 0, 3'd0);
    applyStimulus(0, 0, '0, 1, 0, 3'd0);
    for (int a = 0; a < ND; a++) applyStimulus(0, 0, '0, 0, 1, 3'(a));

    // Swap and Load_start together while full: swap wins
    loadSeq(50, 0, 3'd0);
    applyStimulus(1, 0, '0, 1, 1, 3'd3);
    checkOutput("simul_ready", 64'(load_ready), 64'(0));
    applyStimulus(0, 0, '0, 0, 1, 3'd3);

    // Random traffic
    for (int c = 0; c < 1200; c++) begin
      applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, BW'($urandom),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, 3'($urandom));
    end

    // Out-of-range address on a 6-deep instance
    sReadEn = 1'b1; sReadAddr = 3'd7;
    @(posedge clk);
    #1;
    checkOutput("oob_valid", 64'(sReadValid), 64'(1));
    checkOutput("oob_data",  64'(sReadData),  64'(0));
    sReadEn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("oob_valid_drop", 64'(sReadValid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_buffer_pingpong.md
Name: weight_buffer_pingpong

Overview:
Double-buffered (ping-pong) filter-weight store for the convolution datapath.
- Filter weights stream into a shadow bank through a valid/ready loader.
- The compute side reads all Nr_feature weights plus bias of one filter per cycle from the active bank.
- Banks swap on request once the shadow bank is completely loaded, so the next layer's weights can load while the current layer computes.

Parameters:
Bit_width, 8, bits per weight/bias word
Nr_depth, 8, filters per bank
Depth_counter_bits, 3, address width for filter index; 2**Depth_counter_bits >= Nr_depth
Nr_feature, 6, words per filter (weights + bias) = read lanes
Feature_counter_bits, 3, loader feature-counter width; 2**Feature_counter_bits >= Nr_feature

Ports:
Clk  in  1  clock, all logic on rising edge
Reset_n  in  1  asynchronous active-low reset
Load_start  in  1  pulse: clear loader pointers, begin filling shadow bank
Load_valid  in  1  Load_data valid
Load_ready  out  1  loader accepts a word this cycle
Load_data  in  Bit_width  weight word, feature index fastest, then filter index
Shadow_full  out  1  shadow bank completely loaded, awaiting swap
Swap_req  in  1  request bank swap
Swap_ack  out  1  one-cycle pulse: swap performed
Active_bank  out  1  bank currently served to read port
Read_en  in  1  read request
Read_addr  in  Depth_counter_bits  filter index to read
Read_valid  out  1  Read_data valid
Read_data  out  Bit_width*Nr_feature  lane f at bits [f*Bit_width +: Bit_width]

Behaviour:
- Storage: 2 banks x Nr_depth x Nr_feature words. Contents are not reset.
- Reset (async, Reset_n=0):
  - state=IDLE
  - Active_bank=0, Load_ready=0, Shadow_full=0, Swap_ack=0, Read_valid=0, Read_data=0
  - loader pointers feat=0, filt=0
- Loader FSM states: IDLE, LOAD, FULL.
  - IDLE: Load_ready=0. Load_start -> LOAD, feat=0, filt=0.
  - LOAD: Load_ready=1. Each beat with Load_valid&Load_ready writes shadow[filt][feat].
    - If feat==Nr_feature-1: feat=0, filt++. Otherwise feat++.
    - The beat writing filt==Nr_depth-1, feat==Nr_feature-1 -> FULL.
  - FULL: Load_ready=0, Shadow_full=1.
    - Swap_req -> Active_bank toggles, Swap_ack=1 for exactly that cycle, -> IDLE, Shadow_full=0.
- Shadow bank is always !Active_bank.
- Boundary rules:
  - Load_start in LOAD: restart, pointers cleared, partial data abandoned; the same-cycle beat is not written.
  - Load_start in FULL without Swap_req: -> LOAD, Shadow_full=0, data discarded.
  - Swap_req and Load_start together in FULL: swap wins, Load_start ignored.
  - Swap_req in IDLE or LOAD: ignored, no Swap_ack, Active_bank unchanged.
  - Load_valid while Load_ready=0: no write, no pointer change.
- Read port:
  - Read_en sampled at rising edge; Read_data and Read_valid registered, latency 1.
  - Read_valid = Read_en delayed one cycle. Read_data holds its last value when Read_en=0.
  - A read in the swap cycle returns the old active bank; the new bank is visible from the next cycle.
  - Read_addr >= Nr_depth: Read_valid=1, Read_data=0.
- Reads never see the shadow bank; loader writes never touch the active bank.
- Reset mid-load or mid-swap: immediate return to reset values. Any pending swap is lost.

Test Plan:
- Reset: Reset_n low mid-LOAD -> Load_ready=0, Active_bank=0, Read_valid=0, Read_data=0, all outputs held while low.
- Full load then swap, defaults: Load_start; 48 beats of data 1..48, Load_valid always 1 -> Load_ready high 48 cycles, Shadow_full=1 after beat 48. Swap_req -> Swap_ack one cycle, Active_bank=1. Read_addr=2 -> next-cycle lanes 0..5 = 13..18.
- Backpressure/gaps: Load_valid toggled 1,0,1,0 for 48 accepted words -> contents identical to the previous test. Load_valid while FULL -> no write, Load_ready=0.
- Ping-pong isolation: bank1 active holding 1..48; load 100..147 into bank0 while reading addr 0 every cycle -> reads return 1..6 until the swap cycle inclusive, then 100..105.
- Early/ignored swap: Swap_req during LOAD after 20 beats -> no Swap_ack, Active_bank unchanged. Load_start after 30 beats -> restart, next 48 beats define bank contents.
- Simultaneous Swap_req+Load_start in FULL -> swap occurs, state IDLE, Load_ready=0. Read_addr=7 with Nr_depth=6 override -> Read_valid=1, Read_data=0.
